// File: rtl/seg_scan_arbiter.sv
// ---------------------------------------------------------------------------
// seg_scan_arbiter
//
// Shares one 4-digit multiplexed 7-segment display between two requesters.
// A is the time/counter datapath and B is the setting/message path.
// Ownership changes only at frame boundaries. The owner's BCD digits and
// decimal points are captured once per frame, so a frame never mixes digits
// from two sources. Each digit slot is lit for SCAN_DIV-BLANK_CYC cycles and
// then blanked for BLANK_CYC cycles to suppress ghosting.
//
// Parameters:
//   SCAN_DIV   clock cycles per digit slot (>= 2)
//   BLANK_CYC  trailing all-off cycles of each slot (1 <= BLANK_CYC < SCAN_DIV)
//   MIN_HOLD   minimum frames an owner keeps the display while requesting (>= 1)
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-low
//   req_a       requester A wants the display
//   dig_a[15:0] A digits as BCD nibbles, [3:0] = digit 0 ... [15:12] = digit 3
//   dp_a[3:0]   A decimal points, bit i = digit i, 1 = lit
//   req_b       requester B wants the display
//   dig_b[15:0] B digits, same layout as dig_a
//   dp_b[3:0]   B decimal points
//   gnt_a       A owns the display
//   gnt_b       B owns the display
//   seg[7:0]    segments, active-low, [7] = dp, [6:0] = a..g
//   an[3:0]     digit enables, active-low, an[i] low selects digit i
//   frame_tick  one-cycle pulse on the last cycle of each frame
// ---------------------------------------------------------------------------
module seg_scan_arbiter #(
  parameter int SCAN_DIV  = 65536,
  parameter int BLANK_CYC = 256,
  parameter int MIN_HOLD  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] dig_a,
  input  logic [3:0]  dp_a,
  input  logic        req_b,
  input  logic [15:0] dig_b,
  input  logic [3:0]  dp_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

  localparam logic [SW-1:0] SC_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SC_PRE   = SW'(SCAN_DIV - 2);
  localparam logic [SW-1:0] SC_ON    = SW'(SCAN_DIV - BLANK_CYC);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Owner encoding used by owner/last_owner: 0 = A, 1 = B.
  state_t        state, state_d;
  logic          owner, owner_d;
  logic          last_owner, last_owner_d;
  logic [SW-1:0] sc, sc_d;
  logic [1:0]    di, di_d;
  logic [HW-1:0] hold, hold_d;
  logic          load;
  logic [15:0]   snap_dig;
  logic [3:0]    snap_dp;

  logic          owner_req;
  logic          other_req;
  logic          frame_end;

  logic [3:0]    cur_digit;
  logic          cur_dp;
  logic [7:0]    seg_d;
  logic [3:0]    an_d;
  logic          tick_d;
  logic          gnt_a_d;
  logic          gnt_b_d;

  // BCD to segments a..g, active-low; anything above 9 shows a dash (g only).
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111110;
    endcase
    return s;
  endfunction

  assign owner_req = owner ? req_b : req_a;
  assign other_req = owner ? req_a : req_b;
  assign frame_end = (state == SCAN) && (di == 2'd3) && (sc == SC_LAST);

  // State register plus all counters, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      sc         <= '0;
      di         <= '0;
      hold       <= '0;
      snap_dig   <= '0;
      snap_dp    <= '0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      seg        <= 8'hFF;
      an         <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      sc         <= sc_d;
      di         <= di_d;
      hold       <= hold_d;
      if (load) begin
        snap_dig <= owner_d ? dig_b : dig_a;
        snap_dp  <= owner_d ? dp_b  : dp_a;
      end
      gnt_a      <= gnt_a_d;
      gnt_b      <= gnt_b_d;
      seg        <= seg_d;
      an         <= an_d;
      frame_tick <= tick_d;
    end
  end

  // Next state, slot/digit counters and frame-boundary arbitration.
  // The snapshot reloads on every frame start, including when the owner
  // is kept, so the new frame always shows the owner's current digits.
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    sc_d         = sc;
    di_d         = di;
    hold_d       = hold;
    load         = 1'b0;

    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          state_d = SCAN;
          // On a tie the requester that did not own the display last wins.
          if (req_a && req_b) begin
            owner_d = ~last_owner;
          end else begin
            owner_d = req_b;
          end
          sc_d   = '0;
          di_d   = '0;
          hold_d = '0;
          load   = 1'b1;
        end
      end

      SCAN: begin
        if (sc == SC_LAST) begin
          sc_d = '0;
          di_d = di + 2'd1;
        end else begin
          sc_d = sc + 1'b1;
        end

        if (frame_end) begin
          if (owner_req && (hold < HOLD_MAX)) begin
            hold_d = hold + 1'b1;
            load   = 1'b1;
          end else if (other_req) begin
            owner_d = ~owner;
            hold_d  = '0;
            load    = 1'b1;
          end else if (owner_req) begin
            load = 1'b1;
          end else begin
            state_d      = IDLE;
            last_owner_d = owner;
            sc_d         = '0;
            di_d         = '0;
            hold_d       = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the next edge, derived from the current counters so
  // seg/an trail the counters by one cycle. frame_tick is computed one slot
  // cycle early so its registered pulse lands on the sc == SCAN_DIV-1 cycle.
  always_comb begin
    cur_digit = snap_dig[{di, 2'b00} +: 4];
    cur_dp    = snap_dp[di];
    seg_d     = 8'hFF;
    an_d      = 4'hF;

    if ((state == SCAN) && (sc < SC_ON)) begin
      an_d  = ~(4'b0001 << di);
      seg_d = {~cur_dp, decode(cur_digit)};
    end

    tick_d  = (state == SCAN) && (di == 2'd3) && (sc == SC_PRE);
    gnt_a_d = (state_d == SCAN) && !owner_d;
    gnt_b_d = (state_d == SCAN) &&  owner_d;
  end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_arbiter
//
// Directed bench for seg_scan_arbiter with SCAN_DIV=8, BLANK_CYC=2,
// MIN_HOLD=2. Cycle c0 is the first sampling point after the edge that
// moves the arbiter from IDLE into SCAN. With the one-cycle output lag,
// digit slot s is lit at c(8s+1)..c(8s+6) and blank at c(8s+7), c(8s+8),
// and frame_tick is high at c31, c63, ... All sampling is on the falling
// edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_seg_scan_arbiter;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int MIN_HOLD  = 2;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        req_a = 1'b0;
  logic [15:0] dig_a = '0;
  logic [3:0]  dp_a  = '0;
  logic        req_b = 1'b0;
  logic [15:0] dig_b = '0;
  logic [3:0]  dp_b  = '0;
  logic        gnt_a;
  logic        gnt_b;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  seg_scan_arbiter #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .MIN_HOLD  (MIN_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .dig_a      (dig_a),
    .dp_a       (dp_a),
    .req_b      (req_b),
    .dig_b      (dig_b),
    .dp_b       (dp_b),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic ra, input logic [15:0] da, input logic [3:0] pa,
                               input logic rb, input logic [15:0] db, input logic [3:0] pb);
    req_a = ra;
    dig_a = da;
    dp_a  = pa;
    req_b = rb;
    dig_b = db;
    dp_b  = pb;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h (c%0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkDisp(input string tag, input logic [3:0] an_exp, input logic [7:0] seg_exp);
    checkOutput({tag, " an"}, {28'd0, an}, {28'd0, an_exp});
    checkOutput({tag, " seg"}, {24'd0, seg}, {24'd0, seg_exp});
  endtask

  task automatic goTo(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    // Reset held with req_a asserted
    applyStimulus(1'b1, 16'h1290, 4'b0010, 1'b0, 16'h0000, 4'b0000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst gnt_a", {31'd0, gnt_a}, 32'd0);
    checkOutput("rst gnt_b", {31'd0, gnt_b}, 32'd0);
    checkDisp("rst", 4'hF, 8'hFF);
    checkOutput("rst frame_tick", {31'd0, frame_tick}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    cyc = 0;
    checkOutput("release gnt_a", {31'd0, gnt_a}, 32'd1);
    checkOutput("release gnt_b", {31'd0, gnt_b}, 32'd0);
    checkDisp("c0 lag", 4'hF, 8'hFF);

    // Scan and decode of 16'h1290 with dp on digit 1
    goTo(1);  checkDisp("slot0 first", 4'b1110, 8'b10000001);
    goTo(6);  checkDisp("slot0 last", 4'b1110, 8'b10000001);
    goTo(7);  checkDisp("slot0 blank", 4'hF, 8'hFF);
    goTo(8);  checkDisp("slot0 blank2", 4'hF, 8'hFF);
    goTo(9);  checkDisp("slot1", 4'b1101, 8'b00000100);
    goTo(10);
    applyStimulus(1'b1, 16'h00A0, 4'b0000, 1'b0, 16'h0000, 4'b0000);
    goTo(17); checkDisp("slot2 frozen", 4'b1011, 8'b10010010);
    goTo(25); checkDisp("slot3 frozen", 4'b0111, 8'b11001111);
    goTo(30); checkOutput("tick c30", {31'd0, frame_tick}, 32'd0);
    goTo(31); checkOutput("tick c31", {31'd0, frame_tick}, 32'd1);
    goTo(32); checkOutput("tick c32", {31'd0, frame_tick}, 32'd0);

    // Invalid BCD and mid-frame input change
    goTo(33); checkDisp("f2 slot0", 4'b1110, 8'b10000001);
    goTo(41); checkDisp("f2 slot1 dash", 4'b1101, 8'b11111110);
    goTo(43);
    applyStimulus(1'b1, 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000);
    goTo(46); checkDisp("f2 slot1 held", 4'b1101, 8'b11111110);
    goTo(62); checkOutput("tick c62", {31'd0, frame_tick}, 32'd0);
    goTo(63); checkOutput("tick c63", {31'd0, frame_tick}, 32'd1);
    goTo(73); checkDisp("f3 slot1 zero", 4'b1101, 8'b10000001);
    checkOutput("f3 gnt_a", {31'd0, gnt_a}, 32'd1);

    // Reset mid-frame, then hold/fairness
    applyStimulus(1'b1, 16'h1234, 4'b0000, 1'b0, 16'h5678, 4'b1111);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst gnt_a", {31'd0, gnt_a}, 32'd0);
    checkDisp("midrst", 4'hF, 8'hFF);
    checkOutput("midrst tick", {31'd0, frame_tick}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    cyc = 0;
    checkOutput("hold start gnt_a", {31'd0, gnt_a}, 32'd1);
    goTo(5);
    applyStimulus(1'b1, 16'h1234, 4'b0000, 1'b1, 16'h5678, 4'b1111);
    goTo(32);
    checkOutput("hold f2 gnt_a", {31'd0, gnt_a}, 32'd1);
    checkOutput("hold f2 gnt_b", {31'd0, gnt_b}, 32'd0);
    goTo(33); checkDisp("hold f2 A digit0", 4'b1110, 8'hCC);
    goTo(63);
    checkOutput("hold f2 end gnt_a", {31'd0, gnt_a}, 32'd1);
    checkOutput("hold f2 end tick", {31'd0, frame_tick}, 32'd1);
    goTo(64);
    checkOutput("switch gnt_b", {31'd0, gnt_b}, 32'd1);
    checkOutput("switch gnt_a", {31'd0, gnt_a}, 32'd0);
    goTo(65); checkDisp("B digit0", 4'b1110, 8'h00);
    goTo(89); checkDisp("B digit3", 4'b0111, 8'h24);
    goTo(96); checkOutput("B keeps f4", {31'd0, gnt_b}, 32'd1);
    goTo(128);
    checkOutput("alt back gnt_a", {31'd0, gnt_a}, 32'd1);
    checkOutput("alt back gnt_b", {31'd0, gnt_b}, 32'd0);

    // Release: A drops mid-frame with B idle
    goTo(130);
    applyStimulus(1'b1, 16'h1234, 4'b0000, 1'b0, 16'h5678, 4'b1111);
    goTo(140);
    applyStimulus(1'b0, 16'h9999, 4'b1111, 1'b0, 16'h5678, 4'b1111);
    goTo(145); checkDisp("release slot2", 4'b1011, 8'h92);
    goTo(159);
    checkOutput("release last gnt_a", {31'd0, gnt_a}, 32'd1);
    checkOutput("release last tick", {31'd0, frame_tick}, 32'd1);
    goTo(160);
    checkOutput("idle gnt_a", {31'd0, gnt_a}, 32'd0);
    checkOutput("idle gnt_b", {31'd0, gnt_b}, 32'd0);
    goTo(161); checkDisp("idle", 4'hF, 8'hFF);
    goTo(165); checkDisp("idle later", 4'hF, 8'hFF);

    // Tie from IDLE after reset, then tie after A was last owner
    applyStimulus(1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("tie idle gnt_a", {31'd0, gnt_a}, 32'd0);
    applyStimulus(1'b1, 16'h0000, 4'b0000, 1'b1, 16'h0000, 4'b0000);
    @(negedge clk);
    cyc = 0;
    checkOutput("tie1 gnt_a", {31'd0, gnt_a}, 32'd1);
    checkOutput("tie1 gnt_b", {31'd0, gnt_b}, 32'd0);
    goTo(2);
    applyStimulus(1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000);
    goTo(32);
    checkOutput("tie drop gnt_a", {31'd0, gnt_a}, 32'd0);
    checkOutput("tie drop gnt_b", {31'd0, gnt_b}, 32'd0);
    goTo(33); checkDisp("tie drop idle", 4'hF, 8'hFF);
    goTo(34);
    applyStimulus(1'b1, 16'h0000, 4'b0000, 1'b1, 16'h0000, 4'b0000);
    goTo(35);
    checkOutput("tie2 gnt_b", {31'd0, gnt_b}, 32'd1);
    checkOutput("tie2 gnt_a", {31'd0, gnt_a}, 32'd0);
    goTo(36); checkDisp("tie2 B digit0", 4'b1110, 8'b10000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
